// File: rtl/raw_demosaic_ctrl.sv
// Bayer RAW demosaic timing controller: tracks vsync/href framing, produces per-pixel
// line/point/phase/border tags one cycle after the sampled href, and flags length errors.
module raw_demosaic_ctrl #(
    parameter logic [10:0] IMG_HDISP = 11'd640,
    parameter logic [10:0] IMG_VDISP = 11'd480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        per_frame_vsync,
    input  logic        per_frame_href,
    input  logic        cfg_enable,
    input  logic [1:0]  cfg_bayer_pattern,
    input  logic        err_clr,
    output logic        ctl_valid,
    output logic [10:0] ctl_line,
    output logic [10:0] ctl_point,
    output logic [1:0]  ctl_phase,
    output logic        ctl_border,
    output logic        frame_start,
    output logic        frame_done,
    output logic        err_hlen,
    output logic        err_vlen
);
    localparam int unsigned CW = 11;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT_VS = 2'd1;
    localparam logic [1:0] FRAME   = 2'd2;
    localparam logic [1:0] LINE    = 2'd3;

    logic [1:0]    state;
    logic [1:0]    next_state;
    logic          vs_r;
    logic          hs_r;
    logic [CW-1:0] pix_cnt;
    logic [CW-1:0] line_cnt;
    logic [CW-1:0] lines_next;
    logic [1:0]    pat;
    logic          in_frame;
    logic          start;
    logic          pix_take;
    logic          pix_ok;
    logic          line_end;
    logic          frame_end;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    // Next state and per-cycle event strobes; a low enable overrides everything.
    always_comb begin
        next_state = state;
        in_frame   = 1'b0;
        start      = 1'b0;
        line_end   = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_enable) next_state = WAIT_VS;
            end
            WAIT_VS: begin
                if (per_frame_vsync && !vs_r) begin
                    next_state = FRAME;
                    start      = 1'b1;
                end
            end
            FRAME: begin
                in_frame = 1'b1;
                if (!per_frame_vsync)    next_state = WAIT_VS;
                else if (per_frame_href) next_state = LINE;
            end
            LINE: begin
                in_frame = 1'b1;
                line_end = hs_r && (!per_frame_vsync || !per_frame_href);
                if (!per_frame_vsync)     next_state = WAIT_VS;
                else if (!per_frame_href) next_state = FRAME;
            end
            default: next_state = IDLE;
        endcase
        pix_take  = in_frame && per_frame_vsync && per_frame_href;
        frame_end = in_frame && !per_frame_vsync;
        if (!cfg_enable) begin
            next_state = IDLE;
            start      = 1'b0;
            line_end   = 1'b0;
            pix_take   = 1'b0;
            frame_end  = 1'b0;
        end
        lines_next = line_end ? sat_inc(line_cnt) : line_cnt;
        pix_ok     = pix_take && (pix_cnt < IMG_HDISP) && (line_cnt < IMG_VDISP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_r <= 1'b0;
            hs_r <= 1'b0;
        end else begin
            vs_r <= per_frame_vsync;
            hs_r <= per_frame_href;
        end
    end

    // Counters, latched pattern and registered pixel tags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt     <= '0;
            line_cnt    <= '0;
            pat         <= 2'b00;
            ctl_valid   <= 1'b0;
            ctl_line    <= '0;
            ctl_point   <= '0;
            ctl_phase   <= 2'b00;
            ctl_border  <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            pix_cnt     <= pix_take ? sat_inc(pix_cnt) : '0;
            frame_start <= start;
            frame_done  <= frame_end;
            ctl_valid   <= pix_ok;
            ctl_border  <= pix_ok && ((line_cnt == '0) || (line_cnt == IMG_VDISP - 11'd1) ||
                                      (pix_cnt == '0) || (pix_cnt == IMG_HDISP - 11'd1));
            if (start) pat <= cfg_bayer_pattern;
            if (start || !cfg_enable) line_cnt <= '0;
            else                      line_cnt <= lines_next;
            // Out-of-range pixels leave the last valid tags in place.
            if (pix_ok) begin
                ctl_line  <= line_cnt;
                ctl_point <= pix_cnt;
                ctl_phase <= {line_cnt[0] ^ pat[1], pix_cnt[0] ^ pat[0]};
            end
        end
    end

    // Sticky error flags; a set in the same cycle as err_clr takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_hlen <= 1'b0;
            err_vlen <= 1'b0;
        end else begin
            if (line_end && (pix_cnt != IMG_HDISP))       err_hlen <= 1'b1;
            else if (err_clr)                              err_hlen <= 1'b0;
            if (frame_end && (lines_next != IMG_VDISP))    err_vlen <= 1'b1;
            else if (err_clr)                              err_vlen <= 1'b0;
        end
    end

endmodule
